// File: rtl/ldreg6_arb_pkg.sv
// Shared types and helpers for the ldreg6 load-register arbiter.
package ldreg6_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP
    } state_t;

    localparam int GAP_W = 4;

    // Lowest index at or above ptr (with wrap) among the first n bits.
    function automatic int rr_pick(
        input logic [7:0] req,
        input int         ptr,
        input int         n
    );
        int         res;
        int         idx;
        logic [2:0] sel;
        res = 0;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                sel = idx[2:0];
                if (req[sel]) res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ldreg6_arb_rr_arb.sv
// Combinational round-robin picker over NREQ request lines.
module rr_arb
    import ldreg6_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   win,
    output logic            valid
);

    logic [7:0] r8;

    always_comb begin
        r8 = '0;
        r8[NREQ-1:0] = req;
        win = IW'(rr_pick(r8, int'(ptr), NREQ));
        valid = |req;
    end

endmodule

// File: rtl/ldreg6_arb.sv
// Round-robin sequencer driving the shared 6-bit load register.
// Optional ownership lock compiled in with LDREG6_ARB_LOCK_EN.
module ldreg6_arb
    import ldreg6_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 6,
    parameter int GAP   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   din,
`ifdef LDREG6_ARB_LOCK_EN
    input  logic [NREQ-1:0]         lock,
`endif
    output logic [WIDTH-1:0]        reg_d,
    output logic                    reg_ld,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [GAP_W-1:0] gap_cnt;
    logic [NREQ-1:0]  req_eff;
    logic [IW-1:0]    ptr_eff;
    logic [IW-1:0]    win;
    logic             win_vld;
    logic [IW-1:0]    nxt_owner;

    assign nxt_owner = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifdef LDREG6_ARB_LOCK_EN
    logic locked;
    logic own_lock;

    assign own_lock = lock[owner];

    // While held, only the owner may win; on release resume after it.
    always_comb begin
        req_eff = req;
        ptr_eff = ptr;
        if (locked && own_lock) begin
            req_eff = req & (NREQ'(1) << owner);
        end else if (locked) begin
            ptr_eff = nxt_owner;
        end
    end
`else
    assign req_eff = req;
    assign ptr_eff = ptr;
`endif

    rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req_eff),
        .ptr   (ptr_eff),
        .win   (win),
        .valid (win_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gap_cnt <= '0;
            reg_d   <= '0;
            reg_ld  <= 1'b0;
            ack     <= '0;
            owner   <= '0;
            busy    <= 1'b0;
`ifdef LDREG6_ARB_LOCK_EN
            locked  <= 1'b0;
`endif
        end else begin
            reg_ld <= 1'b0;
            ack    <= '0;
            unique case (state)
                ST_IDLE: begin
`ifdef LDREG6_ARB_LOCK_EN
                    if (locked && !own_lock) begin
                        locked <= 1'b0;
                        ptr    <= nxt_owner;
                    end
`endif
                    if (win_vld) begin
                        owner  <= win;
                        reg_d  <= din[win*WIDTH +: WIDTH];
                        reg_ld <= 1'b1;
                        ack    <= NREQ'(1) << win;
                        busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ptr <= nxt_owner;
                    if (GAP > 0) begin
                        gap_cnt <= GAP_W'(GAP - 1);
                        state   <= ST_GAP;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
`ifdef LDREG6_ARB_LOCK_EN
                        if (own_lock) begin
                            locked <= 1'b1;
                            ptr    <= owner;
                        end
`endif
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
`ifdef LDREG6_ARB_LOCK_EN
                        if (own_lock) begin
                            locked <= 1'b1;
                            ptr    <= owner;
                        end
`endif
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldreg6_arb.sv
// Directed bench for ldreg6_arb: cycle table plus reset, GAP=0 and lock sequences.
module tb_ldreg6_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [23:0] din;
    logic [3:0]  lock;
    logic [5:0]  reg_d,  reg_d0;
    logic        reg_ld, reg_ld0;
    logic [3:0]  ack,    ack0;
    logic [1:0]  owner,  owner0;
    logic        busy,   busy0;

    int tests;
    int fails;

    ldreg6_arb #(.NREQ(4), .WIDTH(6), .GAP(2)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .din    (din),
`ifdef LDREG6_ARB_LOCK_EN
        .lock   (lock),
`endif
        .reg_d  (reg_d),
        .reg_ld (reg_ld),
        .ack    (ack),
        .owner  (owner),
        .busy   (busy)
    );

    ldreg6_arb #(.NREQ(4), .WIDTH(6), .GAP(0)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .din    (din),
`ifdef LDREG6_ARB_LOCK_EN
        .lock   (lock),
`endif
        .reg_d  (reg_d0),
        .reg_ld (reg_ld0),
        .ack    (ack0),
        .owner  (owner0),
        .busy   (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [23:0] din;
        logic        ld;
        logic [5:0]  d;
        logic [3:0]  ack;
        logic [1:0]  own;
        logic        busy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic [3:0] r, input logic [23:0] dn, input logic l,
        input logic [5:0] d, input logic [3:0] a, input logic [1:0] o,
        input logic b
    );
        vec_t v;
        v.req = r; v.din = dn; v.ld = l; v.d = d;
        v.ack = a; v.own = o; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input string nm, input logic [3:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack != 4'b0) seen = 1'b1;
        end
        chk(nm, 32'(ack), 32'(exp));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [23:0] DB = {6'h33, 6'h22, 6'h11, 6'h05};
    localparam logic [23:0] DA = {6'h00, 6'h2A, 6'h00, 6'h00};
    localparam logic [23:0] DC = {6'h00, 6'h00, 6'h15, 6'h00};
    localparam logic [23:0] DD = {6'h3C, 6'h01, 6'h02, 6'h03};

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        lock  = '0;

        for (int i = 0; i < 10; i++)
            tv.push_back(mk(4'h0, 24'h0, 0, 6'h00, 4'h0, 2'd0, 0));
        // all four requesting: 0,1,2,3,0 every 4 cycles
        for (int g = 0; g < 4; g++) begin
            tv.push_back(mk(4'hF, DB, 1, DB[g*6 +: 6], 4'(1 << g), 2'(g), 1));
            tv.push_back(mk(4'hF, DB, 0, DB[g*6 +: 6], 4'h0, 2'(g), 1));
            tv.push_back(mk(4'hF, DB, 0, DB[g*6 +: 6], 4'h0, 2'(g), 1));
            tv.push_back(mk(4'hF, DB, 0, DB[g*6 +: 6], 4'h0, 2'(g), 0));
        end
        tv.push_back(mk(4'hF, DB, 1, 6'h05, 4'b0001, 2'd0, 1));
        tv.push_back(mk(4'h0, DB, 0, 6'h05, 4'h0, 2'd0, 1));
        tv.push_back(mk(4'h0, DB, 0, 6'h05, 4'h0, 2'd0, 1));
        tv.push_back(mk(4'h0, DB, 0, 6'h05, 4'h0, 2'd0, 0));
        // single request from requester 2
        tv.push_back(mk(4'b0100, DA, 1, 6'h2A, 4'b0100, 2'd2, 1));
        tv.push_back(mk(4'h0, DA, 0, 6'h2A, 4'h0, 2'd2, 1));
        tv.push_back(mk(4'h0, DA, 0, 6'h2A, 4'h0, 2'd2, 1));
        tv.push_back(mk(4'h0, DA, 0, 6'h2A, 4'h0, 2'd2, 0));
        // one-cycle pulse on requester 1, dropped during LOAD
        tv.push_back(mk(4'b0010, DC, 1, 6'h15, 4'b0010, 2'd1, 1));
        tv.push_back(mk(4'h0, 24'h0, 0, 6'h15, 4'h0, 2'd1, 1));
        tv.push_back(mk(4'h0, 24'h0, 0, 6'h15, 4'h0, 2'd1, 1));
        tv.push_back(mk(4'h0, 24'h0, 0, 6'h15, 4'h0, 2'd1, 0));
        tv.push_back(mk(4'h0, 24'h0, 0, 6'h15, 4'h0, 2'd1, 0));
        // ptr=2, req 1011: 3 wins by wrap order
        tv.push_back(mk(4'b1011, DD, 1, 6'h3C, 4'b1000, 2'd3, 1));
        tv.push_back(mk(4'h0, DD, 0, 6'h3C, 4'h0, 2'd3, 1));
        tv.push_back(mk(4'h0, DD, 0, 6'h3C, 4'h0, 2'd3, 1));
        tv.push_back(mk(4'h0, DD, 0, 6'h3C, 4'h0, 2'd3, 0));
        // ptr wrapped to 0, req 0110: 1 wins
        tv.push_back(mk(4'b0110, DD, 1, 6'h02, 4'b0010, 2'd1, 1));
        tv.push_back(mk(4'h0, DD, 0, 6'h02, 4'h0, 2'd1, 1));
        tv.push_back(mk(4'h0, DD, 0, 6'h02, 4'h0, 2'd1, 1));
        tv.push_back(mk(4'h0, DD, 0, 6'h02, 4'h0, 2'd1, 0));

        repeat (2) @(negedge clk);
        chk("rst ld", 32'(reg_ld), 32'd0);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst d", 32'(reg_d), 32'd0);
        chk("rst owner", 32'(owner), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            req = tv[i].req;
            din = tv[i].din;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d ld", i), 32'(reg_ld), 32'(tv[i].ld));
            chk($sformatf("v%0d d", i), 32'(reg_d), 32'(tv[i].d));
            chk($sformatf("v%0d ack", i), 32'(ack), 32'(tv[i].ack));
            chk($sformatf("v%0d owner", i), 32'(owner), 32'(tv[i].own));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].busy));
        end

        // reset during LOAD: ptr is 2 here, grant 3 then abort
        req = 4'b1000;
        din = DD;
        @(posedge clk);
        @(negedge clk);
        req = '0;
        chk("pre-abort ld", 32'(reg_ld), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort ld", 32'(reg_ld), 32'd0);
        chk("abort ack", 32'(ack), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort d", 32'(reg_d), 32'd0);
        chk("abort owner", 32'(owner), 32'd0);
        req = 4'b1001;
        @(posedge clk);
        @(negedge clk);
        req = '0;
        chk("post-abort ack", 32'(ack), 32'b0001);
        chk("post-abort d", 32'(reg_d), 32'h03);
        repeat (4) @(negedge clk);

        // GAP=0: continuous requests load every 2 cycles
        pulse_reset();
        req = 4'hF;
        din = DB;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("g0 c%0d ld", c), 32'(reg_ld0), 32'((c % 2) == 0));
            chk($sformatf("g0 c%0d ack", c), 32'(ack0),
                (c % 2) == 0 ? 32'(1 << (c / 2)) : 32'd0);
            chk($sformatf("g0 c%0d d", c), 32'(reg_d0), 32'(DB[(c/2)*6 +: 6]));
        end
        req = '0;
        repeat (4) @(negedge clk);

`ifdef LDREG6_ARB_LOCK_EN
        pulse_reset();
        lock = 4'b1000;
        req  = 4'b1000;
        wait_ack("lock g1", 4'b1000);
        req = 4'b1001;
        wait_ack("lock g2", 4'b1000);
        lock = 4'b0000;
        wait_ack("lock release", 4'b0001);
        req = '0;
        repeat (4) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
